// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// word geometry and the default memory capacity.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD    = 4;
    localparam int MEM_BYTES_DEFAULT = 132;

    // Little-endian byte lane selection: lane 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        word_byte = word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit program words into a byte-wide instruction memory, one byte
// per cycle, while holding the core in reset until the program is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              cpu_hold,
    output logic [15:0]       word_count
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] WORD_STEP = (ADDR_W + 1)'(BYTES_PER_WORD);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [15:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;

    logic [ADDR_W:0]   base_plus4_s;
    logic              full_s;
    logic [ADDR_W-1:0] base_next_s;

    // Address arithmetic is one bit wider than the port so the base can never wrap.
    always_comb begin
        base_plus4_s = {1'b0, base_q} + WORD_STEP;
        full_s       = (base_plus4_s > MEM_LIMIT);
        if (full_s) begin
            base_next_s = MEM_LIMIT[ADDR_W-1:0];
        end else begin
            base_next_s = base_plus4_s[ADDR_W-1:0];
        end
    end

    // Next-state, datapath and output decode for the load sequence.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                    base_d  = '0;
                    count_d = 16'd0;
                    ovf_d   = 1'b0;
                    idx_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ACCEPT: begin
                if (word_valid) begin
                    if (full_s) begin
                        // Word is consumed so the source is not stalled, but nothing is written.
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        word_d  = word_data;
                        last_d  = word_last;
                        idx_d   = 2'd0;
                        we_d    = 1'b1;
                        addr_d  = base_q;
                        wdata_d = word_byte(word_data, 2'd0);
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_WRITE: begin
                if (idx_q == 2'd3) begin
                    base_d  = base_next_s;
                    count_d = count_q + 16'd1;
                    idx_d   = 2'd0;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    idx_d   = idx_q + 2'd1;
                    we_d    = 1'b1;
                    addr_d  = base_q + ADDR_W'(idx_q + 2'd1);
                    wdata_d = word_byte(word_q, idx_q + 2'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_ACCEPT);
        busy_d  = (state_d == ST_ACCEPT) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        hold_d  = (state_d != ST_DONE);
    end

    // State and output registers; reset also drops any partially written word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            last_q  <= 1'b0;
            count_q <= 16'd0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign word_ready = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign cpu_hold   = hold_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a cycle-annotated byte-write scoreboard
// derived from accepted words checks every memory write and handshake.
module tb_imem_loader;

    localparam int MEM_BYTES = 132;
    localparam int ADDR_W    = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              word_valid = 1'b0;
    logic [31:0]       word_data = 32'd0;
    logic              word_last = 1'b0;
    logic              word_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              cpu_hold;
    logic [15:0]       word_count;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow),
        .cpu_hold(cpu_hold), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    bit  m_active   = 1'b0;
    bit  m_final    = 1'b0;
    bit  m_overflow = 1'b0;
    int  m_base     = 0;
    int  m_count    = 0;
    int  m_ready_cyc = 0;
    int  m_busy_cyc  = 0;
    int  m_done_cyc  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: each accepted word expands into four byte writes at fixed cycles.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            m_active = 1'b0;
            m_final  = 1'b0;
        end else begin
            if (m_active && m_final && cyc >= m_done_cyc) begin
                check_eq("done_rise", done, 1);
                check_eq("hold_release", cpu_hold, 0);
                m_active = 1'b0;
            end
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_we_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", mem_addr, e.addr);
                    check_eq("wr_data", {56'd0, mem_wdata}, {56'd0, e.data});
                    check_eq("wr_cycle", cyc, e.cyc);
                end
            end
            if (m_active && !m_final) begin
                check_eq("word_ready", word_ready, cyc >= m_ready_cyc);
            end else begin
                check_eq("ready_idle", word_ready, 0);
            end
            if (m_active) begin
                check_eq("busy", busy, cyc >= m_busy_cyc);
            end else begin
                check_eq("busy_idle", busy, 0);
            end
            if (word_ready && word_valid) begin
                if (m_base + 4 > MEM_BYTES) begin
                    m_overflow = 1'b1;
                    m_final    = 1'b1;
                    m_done_cyc = cyc + 1;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        e.cyc  = cyc + 1 + k;
                        e.addr = 64'(m_base + k);
                        e.data = word_data[8*k +: 8];
                        exp_q.push_back(e);
                    end
                    m_base      = m_base + 4;
                    m_count     = m_count + 1;
                    m_ready_cyc = cyc + 5;
                    if (word_last) begin
                        m_final    = 1'b1;
                        m_done_cyc = cyc + 5;
                    end
                end
            end
        end
    end

    // Call at posedge+1; pulses start for one cycle.
    task automatic do_start();
        if (!m_active) begin
            m_active    = 1'b1;
            m_final     = 1'b0;
            m_overflow  = 1'b0;
            m_base      = 0;
            m_count     = 0;
            m_ready_cyc = cyc + 2;
            m_busy_cyc  = cyc + 2;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input int gap, input bit poke_start);
        bit ok;
        ok = 1'b0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = word_ready;
        end
        check_eq("accept_in_time", ok, 1);
        @(posedge clk); #1;
        word_valid = 1'b0;
        if (poke_start) begin
            do_start();
        end
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            ok = done;
        end
        check_eq(tag, ok, 1);
    endtask

    task automatic check_final(input string tag);
        check_eq({tag, "_count"}, word_count, m_count);
        check_eq({tag, "_ovf"}, overflow, m_overflow);
        check_eq({tag, "_hold"}, cpu_hold, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_we"}, mem_we, 0);
        check_eq({tag, "_ready"}, word_ready, 0);
        check_eq({tag, "_addr"}, mem_addr, 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_count"}, word_count, 0);
        check_eq({tag, "_hold"}, cpu_hold, 1);
    endtask

    initial begin
        int  n;
        bit  found;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset_n = 1'b1;

        // No load without start, even with a word on offer.
        word_valid = 1'b1;
        word_data  = 32'h1234_5678;
        repeat (10) @(posedge clk);
        #1;
        word_valid = 1'b0;
        check_eq("nostart_count", word_count, 0);
        check_eq("nostart_hold", cpu_hold, 1);

        // Single word with last.
        do_start();
        send_word(32'h009A_84B3, 1'b1, 0, 1'b0);
        wait_done("single_done");
        check_final("single");
        check_eq("single_addr_hold", mem_addr, 3);
        check_eq("single_data_hold", mem_wdata, 8'h00);

        // Three words, valid held high.
        @(posedge clk); #1;
        do_start();
        send_word(32'h0030_0293, 1'b0, 0, 1'b0);
        send_word(32'h0050_3223, 1'b0, 0, 1'b0);
        send_word(32'h0020_0293, 1'b1, 0, 1'b0);
        wait_done("three_done");
        check_final("three");

        // Start pulsed during WRITE plus 3-cycle valid gaps.
        @(posedge clk); #1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_word($urandom, i == 3, 3, 1'b1);
        end
        wait_done("gap_done");
        check_final("gap");

        // Randomized programs.
        for (int p = 0; p < 6; p++) begin
            @(posedge clk); #1;
            do_start();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                send_word($urandom, i == n - 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            end
            wait_done("rand_done");
            check_final("rand");
        end

        // Capacity overflow: 33 words fit, the 34th is discarded.
        @(posedge clk); #1;
        do_start();
        for (int i = 0; i < 34; i++) begin
            send_word($urandom, 1'b0, 0, 1'b0);
        end
        wait_done("ovf_done");
        check_final("ovf");
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_words", word_count, 33);
        check_eq("ovf_last_addr", mem_addr, 131);
        check_eq("ovf_we", mem_we, 0);

        // A new start clears overflow and done.
        @(posedge clk); #1;
        do_start();
        @(posedge clk); #1;
        check_eq("restart_ovf", overflow, 0);
        check_eq("restart_done", done, 0);
        check_eq("restart_count", word_count, 0);
        send_word(32'hDEAD_BEEF, 1'b1, 0, 1'b0);
        wait_done("restart_done_again");
        check_final("restart");

        // Reset during byte 2 of the word at base 8.
        @(posedge clk); #1;
        do_start();
        send_word($urandom, 1'b0, 0, 1'b0);
        send_word($urandom, 1'b0, 0, 1'b0);
        word_valid = 1'b1;
        word_data  = $urandom;
        word_last  = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            found = mem_we && (mem_addr == 64'd10);
        end
        check_eq("reach_byte2", found, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        word_valid = 1'b0;
        check_eq("postrst_count", word_count, 0);
        check_eq("postrst_hold", cpu_hold, 1);
        check_eq("postrst_addr", mem_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 132, meaning instruction-memory capacity in bytes (multiple of 4).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning width of the byte address driven to instruction memory.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock, sole clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a load at byte address 0.
REQ-007 word_valid  input  1  word_data/word_last valid.
REQ-008 word_data  input  32  instruction word to store.
REQ-009 word_last  input  1  marks final word of program.
REQ-010 word_ready  output  1  loader accepts word this cycle.
REQ-011 mem_we  output  1  byte write enable to instruction memory.
REQ-012 mem_addr  output  ADDR_W  byte address of write.
REQ-013 mem_wdata  output  8  byte written.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load finished; level, held until next start.
REQ-016 overflow  output  1  sticky: word offered beyond MEM_BYTES.
REQ-017 cpu_hold  output  1  holds the core in reset while 1.
REQ-018 word_count  output  16  words written since last start.

Function
REQ-019 FSM states SHALL be IDLE, ACCEPT, WRITE, DONE.
REQ-020 IDLE/DONE: start=1 -> ACCEPT next cycle; base address, word_count, overflow, done cleared; cpu_hold=1.
REQ-021 ACCEPT: word_ready=1; word_valid=1 latches word_data and word_last, -> WRITE; word_valid=0 stays in ACCEPT indefinitely.
REQ-022 WRITE: four consecutive cycles, byte index k=0..3; mem_we=1, mem_addr=base+k, mem_wdata=word[8k+7:8k] (little-endian, LSB at lowest address).
REQ-023 After k=3: base+=4, word_count+=1; latched last=1 -> DONE, else -> ACCEPT.
REQ-024 Latency: word accepted at edge N -> byte 0 written cycle N+1, byte 3 cycle N+4, word_ready=1 again cycle N+5; throughput one word per 5 cycles.
REQ-025 Outside WRITE, mem_we=0 and mem_addr/mem_wdata SHALL hold last values.
REQ-026 Full: in ACCEPT with base+4 > MEM_BYTES, an offered word SHALL be accepted and discarded, overflow set, -> DONE; no write issued.
REQ-027 start while in ACCEPT or WRITE SHALL be ignored.
REQ-028 busy=1 in ACCEPT and WRITE only; done=1 in DONE only; cpu_hold=0 only in DONE.
REQ-029 base address SHALL never wrap; it saturates at MEM_BYTES.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, mem_we=0, word_ready=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, word_count=0, cpu_hold=1.
REQ-031 Reset mid-WRITE SHALL abort the partial word; no further bytes written after deassertion.
REQ-032 Reset deassertion SHALL not start a load; start is required.

Structure
REQ-033 Shared package imem_loader_pkg SHALL hold the state enum, BYTES_PER_WORD=4, and MEM_BYTES default.
REQ-034 Single module, no sub-module; FSM, byte index counter and address counter inline.

Verification
REQ-035 start, word 0x009A84B3 with last=1 -> writes B3@0, 84@1, 9A@2, 00@3 on 4 consecutive cycles; done=1, word_count=1, cpu_hold=0.
REQ-036 three words 0x00300293, 0x00503223, 0x00200293 (last on third), valid held high -> 12 byte writes addr 0..11, word_ready high every 5th cycle, word_count=3.
REQ-037 34 words at MEM_BYTES=132, no last -> 33 words written addr 0..131, 34th accepted, overflow=1, done=1, no write to addr 132.
REQ-038 reset_n low during byte k=2 of word at base 8 -> mem_we=0 same cycle, outputs at reset values, no write after release until new start.
REQ-039 start pulsed during WRITE, and word_valid gaps of 3 cycles -> start ignored, ACCEPT waits, addresses remain contiguous.
